idu_decode_queue: RTL
=====================

// Module: idu_decode_queue
// PURPOSE
//  Parametrised multi-lane decoded-instruction queue between the decode stage and issue/ICU.
//  Replaces the fixed two-slot decode pipe register with a DEPTH-entry in-order circular buffer.
//  Accepts up to LANES_IN decoded bundles per cycle with a sparse valid mask, compacted in lane order.
//  Presents the oldest LANES_OUT entries to issue; issue retires a prefix (partial dual/multi-issue).
// PARAMETERS
//  LANES_IN   2    enqueue lanes per cycle (1..DEPTH)
//  LANES_OUT  2    dequeue/presented lanes per cycle (1..DEPTH)
//  DEPTH      8    entries; power of two, >= max(LANES_IN,LANES_OUT)
//  PAYLOAD_W  128  bits per entry (addr, inst, imm, dec_info, reg/csr fields, flags packed by caller)
//  CNT_W      $clog2(DEPTH+1)  derived; occupancy/count width
// PORTS
//  clk          in   1                     core clock
//  rst_n        in   1                     async active-low reset
//  flush_i      in   1                     pipeline flush (branch mispredict/trap); clears queue
//  in_valid_i   in   LANES_IN              per-lane valid mask, any pattern allowed
//  in_payload_i in   LANES_IN*PAYLOAD_W    lane k at [k*PAYLOAD_W +: PAYLOAD_W]
//  in_ready_o   out  1                     group-level ready; all-or-nothing acceptance
//  out_valid_o  out  LANES_OUT             lane j valid iff occupancy > j (always prefix-contiguous)
//  out_payload_o out LANES_OUT*PAYLOAD_W   lane j = j-th oldest entry; zero when lane invalid
//  deq_cnt_i    in   $clog2(LANES_OUT+1)   number of head entries issue consumes this cycle
//  count_o      out  CNT_W                 current occupancy (registered)
//  empty_o      out  1                     count_o == 0
//  full_o       out  1                     count_o == DEPTH
// BEHAVIOUR
//  Reset (async, rst_n=0): rd_ptr=wr_ptr=0, count=0 -> out_valid_o=0, out_payload_o=0,
//   count_o=0, empty_o=1, full_o=0, in_ready_o=1 (when flush_i=0). Storage array is not reset.
//  in_ready_o = !flush_i && (count <= DEPTH-LANES_IN); from registered count only (no deq bypass).
//  Enqueue fire = in_ready_o && |in_valid_i. enq_n = popcount(in_valid_i).
//   Valid lanes written in ascending lane order to wr_ptr, wr_ptr+1, ... (mod DEPTH); gaps compacted.
//   Invalid lanes write nothing. wr_ptr += enq_n on the clock edge.
//  Dequeue: deq_n = min(deq_cnt_i, count, LANES_OUT); rd_ptr += deq_n (mod DEPTH).
//   deq_cnt_i > count is a protocol error: clamped, flagged by bench assertion.
//  count_next = count + enq_n - deq_n; simultaneous enq/deq in one cycle is legal and required.
//  Outputs are combinational reads at rd_ptr+j (mod DEPTH); zero-latency visibility: an entry
//   written on edge N is presented from cycle N+1. No same-cycle input-to-output bypass.
//  Pointer wrap: pointers are log2(DEPTH) bits, wrap naturally; full/empty decided by count only.
//  Flush: highest priority. Next edge rd_ptr=wr_ptr=0, count=0; enqueue and dequeue that cycle
//   ignored (in_ready_o=0 while flush_i=1). Output lanes still show pre-flush contents that cycle.
//  Reset mid-operation: all state cleared asynchronously; outputs go to reset values immediately.
//  No internal stall input: back-pressure is purely via in_ready_o and deq_cnt_i.
// TESTING
//  T1 reset: hold rst_n=0 with in_valid_i=2'b11 -> count_o=0, out_valid_o=0, empty_o=1;
//     release -> in_ready_o=1 next cycle.
//  T2 sparse compaction: enqueue in_valid_i=2'b10 payload B, then 2'b11 payloads C,D ->
//     out lanes show B,C; count_o=3.
//  T3 partial issue: queue A,B,C, deq_cnt_i=1 -> next cycle lane0=B, lane1=C, count_o=2;
//     deq_cnt_i=2 -> empty_o=1.
//  T4 full/backpressure DEPTH=8: fill to 7 -> in_ready_o=0 (7>6); enqueue 2'b11 with
//     deq_cnt_i=2 same cycle -> rejected, count_o=5; next cycle ready=1.
//  T5 wrap: 20 cycles streaming 2-in/2-out random masks -> output order matches scoreboard
//     across >=3 pointer wraps, count_o never exceeds 8.
//  T6 flush: count_o=6, flush_i=1 with in_valid_i=2'b11 and deq_cnt_i=2 ->
//     next cycle count_o=0, empty_o=1, no new entries present.

Source files
------------

// File: rtl/idu_decode_queue.sv
// Multi-lane in-order decoded-instruction queue between decode and issue.
// Each cycle it accepts a sparse group of bundles (compacted in lane order) and presents the oldest LANES_OUT entries.
module idu_decode_queue #(
    parameter int LANES_IN  = 2,
    parameter int LANES_OUT = 2,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 128,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int DEQ_W    = $clog2(LANES_OUT + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic [LANES_IN-1:0]            in_valid_i,
    input  logic [LANES_IN*PAYLOAD_W-1:0]  in_payload_i,
    output logic                           in_ready_o,
    output logic [LANES_OUT-1:0]           out_valid_o,
    output logic [LANES_OUT*PAYLOAD_W-1:0] out_payload_o,
    input  logic [DEQ_W-1:0]               deq_cnt_i,
    output logic [CNT_W-1:0]               count_o,
    output logic                           empty_o,
    output logic                           full_o
);

    // A single-entry queue still gets a 1-bit pointer over two physical slots; the count caps occupancy at one.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam int CMP_W = (CNT_W > DEQ_W) ? CNT_W : DEQ_W;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - LANES_IN);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [PAYLOAD_W-1:0] mem_q [SLOTS];
    logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [CNT_W-1:0]     laneOff [LANES_IN];
    logic [PTR_W-1:0]     wrIdx   [LANES_IN];
    logic [PTR_W-1:0]     rdIdx;
    logic [CNT_W-1:0]     enqN;
    logic [CNT_W-1:0]     enqAcc;
    logic [CMP_W-1:0]     deqN;
    logic                 enqFire;

    assign in_ready_o = !flush_i && (count_q <= READY_MAX);
    assign enqFire    = in_ready_o && (|in_valid_i);
    assign enqAcc     = enqFire ? enqN : '0;

    // Each valid lane goes to the slot after all lower-numbered valid lanes, which closes gaps in the mask.
    always_comb begin
        enqN = '0;
        for (int k = 0; k < LANES_IN; k++) begin
            laneOff[k] = enqN;
            wrIdx[k]   = wrPtr_q + PTR_W'(enqN);
            enqN       = enqN + CNT_W'(in_valid_i[k]);
        end
    end

    always_comb begin
        deqN = CMP_W'(deq_cnt_i);
        if (deqN > CMP_W'(count_q)) begin
            deqN = CMP_W'(count_q);
        end
        if (deqN > CMP_W'(LANES_OUT)) begin
            deqN = CMP_W'(LANES_OUT);
        end
    end

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            wrPtr_d = wrPtr_q + PTR_W'(enqAcc);
            rdPtr_d = rdPtr_q + PTR_W'(deqN);
            count_d = count_q + enqAcc - CNT_W'(deqN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enqFire) begin
            for (int k = 0; k < LANES_IN; k++) begin
                if (in_valid_i[k]) begin
                    mem_q[wrIdx[k]] <= in_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

    always_comb begin
        out_valid_o   = '0;
        out_payload_o = '0;
        rdIdx         = rdPtr_q;
        for (int j = 0; j < LANES_OUT; j++) begin
            rdIdx = rdPtr_q + PTR_W'(j);
            if (count_q > CNT_W'(j)) begin
                out_valid_o[j]                          = 1'b1;
                out_payload_o[j*PAYLOAD_W +: PAYLOAD_W] = mem_q[rdIdx];
            end
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);

endmodule
